regs_seq: RTL and testbench
===========================

REGS_SEQ -- requirements
Module: regs_seq

Interface
REQ-001 SHALL have one clock and reset: the reset is asynchronous and active-high.
REQ-002 cpu_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1 / in_ready  out  1  instruction handshake; transfer when both high at a rising edge.
REQ-005 in_rs_a  in  4 / in_rs_b  in  4 / in_rd  in  4  source A, source B and destination register indices (0 = zero register / no write).
REQ-006 in_pop  in  1  request a stack pop on the A-port read.
REQ-007 src_a_en  out  1 / src_a_pop  out  1 / src_a  out  4  register-file read port A control.
REQ-008 src_b_en  out  1 / src_b  out  4  register-file read port B control.
REQ-009 we  out  1 / src_w  out  4 / val  out  16  register-file write port.
REQ-010 a_in  in  16 / b_in  in  16  register-file read data (may be Z when the port is disabled).
REQ-011 op_valid  out  1 / op_ready  in  1 / op_a  out  16 / op_b  out  16  operand handshake to the execute unit.
REQ-012 res_valid  in  1 / res_ready  out  1 / res  in  16  result handshake from the execute unit.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, READ, EXEC, WAIT_RES, WRITE.
REQ-015 IDLE: in_ready=1; on in_valid SHALL latch rs_a, rs_b, rd, pop and go to READ; otherwise remain.
REQ-016 READ (one cycle): src_a_en=1, src_b_en=1, src_a=rs_a, src_b=rs_b, src_a_pop=pop; at the closing edge SHALL register a_in->op_a, b_in->op_b and go to EXEC.
REQ-017 Outside READ, src_a_en, src_b_en and src_a_pop SHALL be 0 and src_a/src_b SHALL be 0.
REQ-018 EXEC: op_valid=1 with op_a/op_b stable; SHALL hold until op_ready is sampled high, then go to WAIT_RES.
REQ-019 WAIT_RES: res_ready=1; on res_valid SHALL capture res; go to WRITE if rd!=0, else directly to IDLE.
REQ-020 res_valid SHALL be ignored outside WAIT_RES, including when asserted in the same cycle as the op handshake.
REQ-021 WRITE (one cycle): we=1, src_w=rd, val=captured res; then IDLE.
REQ-022 Outside WRITE, src_w SHALL be 0 and we SHALL be 0 so no register is written; val SHALL hold the last captured result.
REQ-023 Minimum latency: accept at edge E0 -> READ cycle 1 -> op_valid cycle 2 -> res_ready cycle 3 -> write cycle 4 -> in_ready cycle 5.
REQ-024 Throughput SHALL be one instruction per 5 cycles minimum; there is no pipelining or bypass.
REQ-025 A write in cycle N SHALL be visible to a READ of the next instruction, because READ occurs no earlier than cycle N+2.
REQ-026 Latched fields SHALL be frozen from accept until return to IDLE; input changes SHALL have no effect.
REQ-027 rd=14/15 (stack pointer low/high) SHALL be written like any other register.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE, and all outputs SHALL be 0 while rst is high: op_a, op_b, val, src_*, en, pop, we, op_valid, res_ready, busy, in_ready.
REQ-029 After rst is released: IDLE, in_ready=1.
REQ-030 A reset mid-operation SHALL abort the instruction with no write issued and no pending handshake retained.

Verification
REQ-031 Reset, then accept rs_a=1, rs_b=2, rd=3, with a_in=0x1234, b_in=0x0005, op_ready=1 and res_valid=1 (res=0x1239) held high -> op_a=0x1234, op_b=0x0005 in cycle 2; WRITE cycle 4 with src_w=3, we=1, val=0x1239; in_ready back at cycle 5.
REQ-032 Hold op_ready low for 3 cycles in EXEC -> op_valid and op_a/op_b held stable; WAIT_RES entered only after the op_ready edge.
REQ-033 Accept with rd=0 and res=0xBEEF -> no cycle with we=1; IDLE directly after the res handshake (4-cycle turnaround).
REQ-034 Accept with in_pop=1, rs_a=14 -> src_a_pop=1 and src_a=14 only in the READ cycle; 0 in all other cycles.
REQ-035 Assert rst in WAIT_RES while res_valid=1 -> we never asserted, busy=0 immediately, then in_ready=1 after release.
REQ-036 Back-to-back: write r5=0x00AA, then next instruction reads rs_a=5 -> op_a=0x00AA.

Source files
------------

// File: rtl/regs_seq_if.sv
//------------------------------------------------------------------------------
// Module      : regs_seq_if
// Description : Bundle of instruction, register-file, operand and result
//               handshake signals shared by the sequencer and its environment.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface regs_seq_if;
  // instruction handshake
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rs_a;
  logic [3:0]  in_rs_b;
  logic [3:0]  in_rd;
  logic        in_pop;
  // register-file read ports
  logic        src_a_en;
  logic        src_a_pop;
  logic [3:0]  src_a;
  logic        src_b_en;
  logic [3:0]  src_b;
  logic [15:0] a_in;
  logic [15:0] b_in;
  // register-file write port
  logic        we;
  logic [3:0]  src_w;
  logic [15:0] val;
  // operand handshake to execute unit
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  // result handshake from execute unit
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res;
  // status
  logic        busy;

  // sequencer side
  modport slave (
    input  in_valid, in_rs_a, in_rs_b, in_rd, in_pop,
    input  a_in, b_in, op_ready, res_valid, res,
    output in_ready, src_a_en, src_a_pop, src_a, src_b_en, src_b,
    output we, src_w, val, op_valid, op_a, op_b, res_ready, busy
  );

  // environment side (issuer, register file, execute unit)
  modport master (
    output in_valid, in_rs_a, in_rs_b, in_rd, in_pop,
    output a_in, b_in, op_ready, res_valid, res,
    input  in_ready, src_a_en, src_a_pop, src_a, src_b_en, src_b,
    input  we, src_w, val, op_valid, op_a, op_b, res_ready, busy
  );
endinterface

`default_nettype wire

// File: rtl/regs_seq.sv
//------------------------------------------------------------------------------
// Module      : regs_seq
// Description : Non-pipelined instruction sequencer: read operands, hand them
//               to the execute unit, wait for the result, write it back.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regs_seq (
  input  wire         cpu_clk,
  input  wire         rst,
  regs_seq_if.slave   bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] READ     = 3'd1;
  localparam logic [2:0] EXEC     = 3'd2;
  localparam logic [2:0] WAIT_RES = 3'd3;
  localparam logic [2:0] WRITE    = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;

  logic [3:0]  rs_a_lat;
  logic [3:0]  rs_b_lat;
  logic [3:0]  rd_lat;
  logic        pop_lat;
  logic [15:0] op_a_reg;
  logic [15:0] op_b_reg;
  logic [15:0] res_reg;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; res_valid only matters while waiting for the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.in_valid) state_nxt = READ;
      READ:     state_nxt = EXEC;
      EXEC:     if (bus.op_ready) state_nxt = WAIT_RES;
      WAIT_RES: if (bus.res_valid) state_nxt = (rd_lat != 4'd0) ? WRITE : IDLE;
      WRITE:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Instruction fields frozen from accept until the next accept.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      rs_a_lat <= 4'd0;
      rs_b_lat <= 4'd0;
      rd_lat   <= 4'd0;
      pop_lat  <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      rs_a_lat <= bus.in_rs_a;
      rs_b_lat <= bus.in_rs_b;
      rd_lat   <= bus.in_rd;
      pop_lat  <= bus.in_pop;
    end
  end

  // Operand capture at the end of the READ cycle.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      op_a_reg <= 16'd0;
      op_b_reg <= 16'd0;
    end else if (state == READ) begin
      op_a_reg <= bus.a_in;
      op_b_reg <= bus.b_in;
    end
  end

  // Result capture on the result handshake; held until the next one.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst)                                   res_reg <= 16'd0;
    else if (state == WAIT_RES && bus.res_valid) res_reg <= bus.res;
  end

  // State-decoded outputs, all forced low while reset is asserted.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.src_a_en  = 1'b0;
    bus.src_b_en  = 1'b0;
    bus.src_a_pop = 1'b0;
    bus.src_a     = 4'd0;
    bus.src_b     = 4'd0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    bus.we        = 1'b0;
    bus.src_w     = 4'd0;
    bus.busy      = 1'b0;
    if (!rst) begin
      bus.busy = (state != IDLE);
      case (state)
        IDLE:     bus.in_ready = 1'b1;
        READ: begin
          bus.src_a_en  = 1'b1;
          bus.src_b_en  = 1'b1;
          bus.src_a     = rs_a_lat;
          bus.src_b     = rs_b_lat;
          bus.src_a_pop = pop_lat;
        end
        EXEC:     bus.op_valid  = 1'b1;
        WAIT_RES: bus.res_ready = 1'b1;
        WRITE: begin
          bus.we    = 1'b1;
          bus.src_w = rd_lat;
        end
        default: ;
      endcase
    end
  end

  assign bus.op_a = op_a_reg;
  assign bus.op_b = op_b_reg;
  assign bus.val  = res_reg;

endmodule

`default_nettype wire

// File: tb/tb_regs_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_regs_seq
// Description : Directed self-checking bench for regs_seq with a small
//               register-file model on the read/write ports.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regs_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  regs_seq_if bus ();

  regs_seq dut (
    .cpu_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Register-file model: r0 reads as zero, writes happen at the clock edge.
  logic [15:0] regs [16];
  logic        clr;
  logic        pl_we;
  logic [3:0]  pl_idx;
  logic [15:0] pl_val;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'd0;
    end else if (pl_we) begin
      regs[pl_idx] <= pl_val;
    end else if (bus.we) begin
      regs[bus.src_w] <= bus.val;
    end
  end

  assign bus.a_in = bus.src_a_en ? ((bus.src_a == 4'd0) ? 16'd0 : regs[bus.src_a]) : 16'hzzzz;
  assign bus.b_in = bus.src_b_en ? ((bus.src_b == 4'd0) ? 16'd0 : regs[bus.src_b]) : 16'hzzzz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd, input logic pop);
    bus.in_valid = 1'b1;
    bus.in_rs_a  = ra;
    bus.in_rs_b  = rb;
    bus.in_rd    = rd;
    bus.in_pop   = pop;
    tick();
    bus.in_valid = 1'b0;
    bus.in_pop   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin bad++;
      $display("FAIL reset_status: busy=%b in_ready=%b want 0/0", bus.busy, bus.in_ready); end
    total++; if ({bus.we, bus.op_valid, bus.res_ready, bus.src_a_en, bus.src_b_en} !== 5'b0) begin bad++;
      $display("FAIL reset_ctrl: we/opv/resr/aen/ben=%b want 00000",
               {bus.we, bus.op_valid, bus.res_ready, bus.src_a_en, bus.src_b_en}); end
    total++; if (bus.op_a !== 16'd0 || bus.op_b !== 16'd0 || bus.val !== 16'd0) begin bad++;
      $display("FAIL reset_data: op_a=%h op_b=%h val=%h want 0", bus.op_a, bus.op_b, bus.val); end
    rst = 1'b0;
    tick();
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++;
      $display("FAIL reset_release: in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy); end
  endtask

  task automatic test_basic();
    pl_we = 1'b1; pl_idx = 4'd1; pl_val = 16'h1234; tick();
    pl_idx = 4'd2; pl_val = 16'h0005; tick();
    pl_we = 1'b0;
    bus.op_ready = 1'b1; bus.res_valid = 1'b1; bus.res = 16'h1239;
    issue(4'd1, 4'd2, 4'd3, 1'b0);
    // cycle 1: READ
    total++; if (bus.src_a_en !== 1'b1 || bus.src_b_en !== 1'b1 || bus.src_a !== 4'd1 || bus.src_b !== 4'd2) begin bad++;
      $display("FAIL basic_read: aen=%b ben=%b src_a=%0d src_b=%0d want 1 1 1 2",
               bus.src_a_en, bus.src_b_en, bus.src_a, bus.src_b); end
    total++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.op_valid !== 1'b0) begin bad++;
      $display("FAIL basic_c1_status: busy=%b in_ready=%b op_valid=%b want 1 0 0",
               bus.busy, bus.in_ready, bus.op_valid); end
    tick();
    // cycle 2: EXEC
    total++; if (bus.op_valid !== 1'b1 || bus.op_a !== 16'h1234 || bus.op_b !== 16'h0005) begin bad++;
      $display("FAIL basic_exec: op_valid=%b op_a=%h op_b=%h want 1 1234 0005",
               bus.op_valid, bus.op_a, bus.op_b); end
    total++; if (bus.res_ready !== 1'b0 || bus.src_a_en !== 1'b0 || bus.src_a !== 4'd0) begin bad++;
      $display("FAIL basic_exec_ctrl: res_ready=%b aen=%b src_a=%0d want 0 0 0",
               bus.res_ready, bus.src_a_en, bus.src_a); end
    tick();
    // cycle 3: WAIT_RES (res_valid seen during EXEC must not skip this)
    total++; if (bus.res_ready !== 1'b1 || bus.we !== 1'b0 || bus.op_valid !== 1'b0) begin bad++;
      $display("FAIL basic_wait: res_ready=%b we=%b op_valid=%b want 1 0 0",
               bus.res_ready, bus.we, bus.op_valid); end
    tick();
    bus.op_ready = 1'b0; bus.res_valid = 1'b0;
    // cycle 4: WRITE
    total++; if (bus.we !== 1'b1 || bus.src_w !== 4'd3 || bus.val !== 16'h1239) begin bad++;
      $display("FAIL basic_write: we=%b src_w=%0d val=%h want 1 3 1239", bus.we, bus.src_w, bus.val); end
    tick();
    // cycle 5: IDLE
    total++; if (bus.in_ready !== 1'b1 || bus.we !== 1'b0 || bus.src_w !== 4'd0 || bus.val !== 16'h1239) begin bad++;
      $display("FAIL basic_idle: in_ready=%b we=%b src_w=%0d val=%h want 1 0 0 1239",
               bus.in_ready, bus.we, bus.src_w, bus.val); end
  endtask

  task automatic test_op_stall();
    bus.op_ready = 1'b0; bus.res_valid = 1'b0;
    issue(4'd3, 4'd1, 4'd4, 1'b0);
    // input changes while busy must be ignored
    bus.in_valid = 1'b1; bus.in_rs_a = 4'd9; bus.in_rs_b = 4'd8; bus.in_rd = 4'd7;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.op_valid !== 1'b1 || bus.op_a !== 16'h1239 || bus.op_b !== 16'h1234 || bus.res_ready !== 1'b0) begin bad++;
        $display("FAIL stall_hold[%0d]: op_valid=%b op_a=%h op_b=%h res_ready=%b want 1 1239 1234 0",
                 k, bus.op_valid, bus.op_a, bus.op_b, bus.res_ready); end
      if (k < 2) tick();
    end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    total++; if (bus.res_ready !== 1'b1 || bus.op_valid !== 1'b0) begin bad++;
      $display("FAIL stall_wait: res_ready=%b op_valid=%b want 1 0", bus.res_ready, bus.op_valid); end
    tick();
    total++; if (bus.res_ready !== 1'b1 || bus.we !== 1'b0) begin bad++;
      $display("FAIL stall_wait_hold: res_ready=%b we=%b want 1 0", bus.res_ready, bus.we); end
    bus.res_valid = 1'b1; bus.res = 16'h4444;
    bus.in_valid = 1'b0;
    tick();
    bus.res_valid = 1'b0;
    total++; if (bus.we !== 1'b1 || bus.src_w !== 4'd4 || bus.val !== 16'h4444) begin bad++;
      $display("FAIL stall_write: we=%b src_w=%0d val=%h want 1 4 4444", bus.we, bus.src_w, bus.val); end
    tick();
  endtask

  task automatic test_no_write();
    int wcount;
    wcount = 0;
    bus.op_ready = 1'b1; bus.res_valid = 1'b1; bus.res = 16'hBEEF;
    issue(4'd1, 4'd2, 4'd0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      if (bus.we !== 1'b0) wcount++;
      tick();
    end
    bus.op_ready = 1'b0; bus.res_valid = 1'b0;
    // cycle 4: already back in IDLE
    total++; if (wcount != 0 || bus.we !== 1'b0) begin bad++;
      $display("FAIL nowrite_we: we-high cycles=%0d we=%b want 0 0", wcount, bus.we); end
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.val !== 16'hBEEF) begin bad++;
      $display("FAIL nowrite_idle: in_ready=%b busy=%b val=%h want 1 0 beef", bus.in_ready, bus.busy, bus.val); end
  endtask

  task automatic test_pop();
    bus.in_pop = 1'b1; bus.in_rs_a = 4'd14;
    #1;
    total++; if (bus.src_a_pop !== 1'b0 || bus.src_a !== 4'd0) begin bad++;
      $display("FAIL pop_idle: pop=%b src_a=%0d want 0 0", bus.src_a_pop, bus.src_a); end
    bus.op_ready = 1'b1; bus.res_valid = 1'b1; bus.res = 16'h0001;
    issue(4'd14, 4'd0, 4'd0, 1'b1);
    total++; if (bus.src_a_pop !== 1'b1 || bus.src_a !== 4'd14) begin bad++;
      $display("FAIL pop_read: pop=%b src_a=%0d want 1 14", bus.src_a_pop, bus.src_a); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      total++; if (bus.src_a_pop !== 1'b0 || bus.src_a !== 4'd0) begin bad++;
        $display("FAIL pop_after[%0d]: pop=%b src_a=%0d want 0 0", k, bus.src_a_pop, bus.src_a); end
    end
    bus.op_ready = 1'b0; bus.res_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.op_ready = 1'b1; bus.res_valid = 1'b0;
    issue(4'd1, 4'd2, 4'd6, 1'b0);
    tick();
    tick();
    bus.op_ready = 1'b0;
    total++; if (bus.res_ready !== 1'b1) begin bad++;
      $display("FAIL rstmid_wait: res_ready=%b want 1", bus.res_ready); end
    bus.res_valid = 1'b1; bus.res = 16'h7777;
    rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.we !== 1'b0 || bus.res_ready !== 1'b0 || bus.in_ready !== 1'b0) begin bad++;
      $display("FAIL rstmid_async: busy=%b we=%b res_ready=%b in_ready=%b want 0 0 0 0",
               bus.busy, bus.we, bus.res_ready, bus.in_ready); end
    total++; if (bus.op_a !== 16'd0 || bus.val !== 16'd0) begin bad++;
      $display("FAIL rstmid_data: op_a=%h val=%h want 0 0", bus.op_a, bus.val); end
    tick();
    total++; if (bus.we !== 1'b0) begin bad++;
      $display("FAIL rstmid_we: we=%b want 0", bus.we); end
    rst = 1'b0;
    tick();
    bus.res_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.we !== 1'b0) begin bad++;
      $display("FAIL rstmid_release: in_ready=%b busy=%b we=%b want 1 0 0", bus.in_ready, bus.busy, bus.we); end
    total++; if (regs[6] !== 16'd0) begin bad++;
      $display("FAIL rstmid_r6: r6=%h want 0000", regs[6]); end
  endtask

  task automatic test_back_to_back();
    bus.op_ready = 1'b1; bus.res_valid = 1'b1; bus.res = 16'h00AA;
    issue(4'd0, 4'd0, 4'd5, 1'b0);
    tick(); tick(); tick();
    total++; if (bus.we !== 1'b1 || bus.src_w !== 4'd5 || bus.val !== 16'h00AA) begin bad++;
      $display("FAIL b2b_write: we=%b src_w=%0d val=%h want 1 5 00aa", bus.we, bus.src_w, bus.val); end
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++;
      $display("FAIL b2b_idle: in_ready=%b want 1", bus.in_ready); end
    issue(4'd5, 4'd3, 4'd0, 1'b0);
    tick();
    total++; if (bus.op_a !== 16'h00AA || bus.op_b !== 16'h1239) begin bad++;
      $display("FAIL b2b_fwd: op_a=%h op_b=%h want 00aa 1239", bus.op_a, bus.op_b); end
    tick(); tick();
    bus.op_ready = 1'b0; bus.res_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; clr = 1'b1;
    pl_we = 1'b0; pl_idx = 4'd0; pl_val = 16'd0;
    bus.in_valid = 1'b0; bus.in_rs_a = 4'd0; bus.in_rs_b = 4'd0; bus.in_rd = 4'd0; bus.in_pop = 1'b0;
    bus.op_ready = 1'b0; bus.res_valid = 1'b0; bus.res = 16'd0;
    total = 0; bad = 0;
    test_reset();
    test_basic();
    test_op_stall();
    test_no_write();
    test_pop();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
